// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: read latency shared by the distram FIFO and its stream reader
package fifo_stream_reader_pkg;
  localparam int FIFO_RD_LATENCY = 2;
endpackage

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a fixed-latency FIFO into a valid/ready stream
// through a small credit-controlled output buffer
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int RD_LATENCY     = FIFO_RD_LATENCY,
  parameter int BUF_DEPTH_BITS = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fifo_empty,
  output logic                    fifo_re,
  input  logic                    fifo_valid,
  input  logic [DATA_WIDTH-1:0]   fifo_dout,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  input  logic                    m_axis_tready,
  output logic [BUF_DEPTH_BITS:0] buf_count,
  output logic                    err_unexpected
);
  localparam int DEPTH = 2 ** BUF_DEPTH_BITS;
  localparam int CW    = BUF_DEPTH_BITS + 1;
  generate
    if (DEPTH < RD_LATENCY + 2 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_params
      $error("fifo_stream_reader: need 1<=RD_LATENCY<=4 and 2**BUF_DEPTH_BITS >= RD_LATENCY+2");
    end
  endgenerate
  logic [1:0]                rst_sync_q;
  logic                      rst_n;
  logic [2:0]                inflight_q, inflight_d;
  logic [CW-1:0]             occ_q, occ_d;
  logic [BUF_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                      err_q, err_d;
  logic [CW:0]               used;
  logic                      capture, pop;
  logic [DATA_WIDTH-1:0]     mem_q [DEPTH];
  // reset asserts immediately but releases only on a clock edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n   = rst_sync_q[1];
  assign used    = (CW+1)'(inflight_q) + (CW+1)'(occ_q);
  // credits ignore a same-cycle pop so the buffer can never overflow
  assign fifo_re = rst_n & ~fifo_empty & (used < (CW+1)'(DEPTH));
  assign capture = fifo_valid & (inflight_q != 3'd0);
  assign pop     = (occ_q != '0) & m_axis_tready;
  always_comb begin
    inflight_d = inflight_q + 3'(fifo_re) - 3'(capture);
    occ_d      = occ_q + CW'(capture) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + BUF_DEPTH_BITS'(capture);
    rd_ptr_d   = rd_ptr_q + BUF_DEPTH_BITS'(pop);
    err_d      = err_q | (fifo_valid & (inflight_q == 3'd0));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      inflight_q <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  always_ff @(posedge clk)
    if (capture) mem_q[wr_ptr_q] <= fifo_dout;
  assign m_axis_tvalid  = occ_q != '0;
  assign m_axis_tdata   = mem_q[rd_ptr_q];
  assign buf_count      = occ_q;
  assign err_unexpected = err_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed tests against a behavioural 2-cycle-latency FIFO
module tb_fifo_stream_reader;
  logic        clk, reset_n;
  logic        fifo_empty, fifo_re, fifo_valid;
  logic [63:0] fifo_dout, m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic [2:0]  buf_count;
  logic        err_unexpected;
  int errors = 0;
  int checks = 0;
  logic [63:0] mem [4096];
  int          wr_idx, rd_idx;
  logic        v1, v2, force_valid;
  logic [63:0] d1, d2;
  logic [63:0] got [$];
  int cyc, first_re, last_re, first_beat, last_beat, re_cnt, max_cnt;
  fifo_stream_reader #(.DATA_WIDTH(64), .RD_LATENCY(2), .BUF_DEPTH_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_re(fifo_re),
    .fifo_valid(fifo_valid), .fifo_dout(fifo_dout), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready), .buf_count(buf_count),
    .err_unexpected(err_unexpected)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  assign fifo_empty = (wr_idx == rd_idx);
  assign fifo_valid = v2 | force_valid;
  assign fifo_dout  = force_valid ? 64'hDEAD_BEEF_0000_0001 : d2;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      v1 <= 0; v2 <= 0; rd_idx <= 0;
    end else begin
      v1 <= fifo_re;
      d1 <= mem[rd_idx];
      if (fifo_re) rd_idx <= rd_idx + 1;
      v2 <= v1;
      d2 <= d1;
    end
  task automatic push(input logic [63:0] w);
    mem[wr_idx] = w;
    wr_idx++;
  endtask
  task automatic clr();
    got.delete();
    first_re = -1; last_re = -1; first_beat = -1; last_beat = -1;
    re_cnt = 0; max_cnt = 0;
  endtask
  task automatic tick();
    #1;
    if (m_axis_tvalid && m_axis_tready) begin
      got.push_back(m_axis_tdata);
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
    end
    if (fifo_re) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
      last_re = cyc;
    end
    if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
    @(negedge clk);
    cyc++;
  endtask
  task automatic do_reset();
    reset_n = 0; m_axis_tready = 0; force_valid = 0; wr_idx = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    clr();
  endtask
  task automatic test_reset();
    reset_n = 0; m_axis_tready = 1; force_valid = 0; wr_idx = 0;
    push(64'h55);
    tick(); tick();
    checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL reset_re got=%b exp=0", fifo_re); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", buf_count); end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_unexpected); end
    do_reset();
  endtask
  task automatic test_basic();
    do_reset();
    m_axis_tready = 1;
    push(64'h11); tick();
    push(64'h22); tick();
    push(64'h33); tick();
    repeat (12) tick();
    checks++; if (first_beat - first_re !== 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", first_beat - first_re); end
    checks++; if (got.size() !== 3) begin errors++; $display("FAIL basic_count got=%0d exp=3", got.size()); end
    if (got.size() == 3) begin
      checks++; if (got[0] !== 64'h11) begin errors++; $display("FAIL basic_w0 got=%h exp=11", got[0]); end
      checks++; if (got[1] !== 64'h22) begin errors++; $display("FAIL basic_w1 got=%h exp=22", got[1]); end
      checks++; if (got[2] !== 64'h33) begin errors++; $display("FAIL basic_w2 got=%h exp=33", got[2]); end
    end
    checks++; if (last_beat - first_beat !== 2) begin errors++; $display("FAIL basic_consecutive got=%0d exp=2", last_beat - first_beat); end
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL basic_drained got=%0d exp=0", buf_count); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    m_axis_tready = 1;
    for (int i = 0; i < 100; i++) push(64'h5000 + 64'(i));
    repeat (120) tick();
    checks++; if (got.size() !== 100) begin errors++; $display("FAIL b2b_count got=%0d exp=100", got.size()); end
    for (int i = 0; i < got.size() && i < 100; i++) begin
      checks++; if (got[i] !== 64'h5000 + 64'(i)) begin errors++; $display("FAIL b2b_word%0d got=%h exp=%h", i, got[i], 64'h5000 + 64'(i)); end
    end
    checks++; if (last_re - first_re !== 99 || re_cnt !== 100) begin errors++; $display("FAIL b2b_re_span got=%0d/%0d exp=99/100", last_re - first_re, re_cnt); end
    checks++; if (last_beat - first_beat !== 99) begin errors++; $display("FAIL b2b_beat_span got=%0d exp=99", last_beat - first_beat); end
  endtask
  task automatic test_backpressure();
    logic [63:0] held;
    do_reset();
    for (int i = 0; i < 16; i++) push(64'h1000 + 64'(i));
    repeat (10) tick();
    checks++; if (re_cnt !== 4) begin errors++; $display("FAIL bp_reads got=%0d exp=4", re_cnt); end
    checks++; if (buf_count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", buf_count); end
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h1000) begin errors++; $display("FAIL bp_head got=%b/%h exp=1/1000", m_axis_tvalid, m_axis_tdata); end
    held = m_axis_tdata;
    repeat (3) tick();
    checks++; if (m_axis_tdata !== held || fifo_re !== 1'b0) begin errors++; $display("FAIL bp_stable got=%h re=%b exp=%h re=0", m_axis_tdata, fifo_re, held); end
    m_axis_tready = 1;
    repeat (40) tick();
    checks++; if (got.size() !== 16) begin errors++; $display("FAIL bp_drain_count got=%0d exp=16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      checks++; if (got[i] !== 64'h1000 + 64'(i)) begin errors++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], 64'h1000 + 64'(i)); end
    end
  endtask
  task automatic test_random();
    int bad;
    do_reset();
    for (int i = 0; i < 1000; i++) push({$urandom(), $urandom()});
    for (int n = 0; n < 6000 && got.size() < 1000; n++) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      tick();
    end
    checks++; if (got.size() !== 1000) begin errors++; $display("FAIL rand_count got=%0d exp=1000", got.size()); end
    bad = 0;
    for (int i = 0; i < got.size() && i < 1000; i++) if (got[i] !== mem[i]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_order got=%0d wrong words exp=0", bad); end
    checks++; if (max_cnt > 4) begin errors++; $display("FAIL rand_maxcount got=%0d exp<=4", max_cnt); end
  endtask
  task automatic test_unexpected();
    do_reset();
    tick();
    force_valid = 1;
    tick();
    force_valid = 0;
    tick();
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_err got=%b exp=1", err_unexpected); end
    checks++; if (buf_count !== 3'd0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL unexp_count got=%0d/%b exp=0/0", buf_count, m_axis_tvalid); end
    m_axis_tready = 1;
    push(64'h77);
    repeat (8) tick();
    checks++; if (err_unexpected !== 1'b1) begin errors++; $display("FAIL unexp_sticky got=%b exp=1", err_unexpected); end
    checks++; if (got.size() !== 1 || got[0] !== 64'h77) begin errors++; $display("FAIL unexp_after got=%0d words exp=1 word 77", got.size()); end
  endtask
  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) push(64'hB0 + 64'(i));
    for (int n = 0; n < 20 && buf_count != 3'd3; n++) tick();
    checks++; if (buf_count !== 3'd3) begin errors++; $display("FAIL areset_fill got=%0d exp=3", buf_count); end
    #2 reset_n = 0;
    wr_idx = 0;
    #1;
    checks++; if (m_axis_tvalid !== 1'b0 || fifo_re !== 1'b0) begin errors++; $display("FAIL areset_outputs got=%b/%b exp=0/0", m_axis_tvalid, fifo_re); end
    checks++; if (buf_count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", buf_count); end
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (3) tick();
    clr();
    m_axis_tready = 1;
    push(64'hA1); push(64'hA2);
    repeat (15) tick();
    checks++; if (got.size() !== 2) begin errors++; $display("FAIL areset_resume_count got=%0d exp=2", got.size()); end
    if (got.size() == 2) begin
      checks++; if (got[0] !== 64'hA1 || got[1] !== 64'hA2) begin errors++; $display("FAIL areset_resume_data got=%h,%h exp=a1,a2", got[0], got[1]); end
    end
    checks++; if (err_unexpected !== 1'b0) begin errors++; $display("FAIL areset_err got=%b exp=0", err_unexpected); end
  endtask
  initial begin
    reset_n = 1; m_axis_tready = 0; force_valid = 0; wr_idx = 0; cyc = 0;
    clr();
    #3;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_unexpected();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL timeout reached without completing the test sequence");
    $fatal(1, "timeout");
  end
endmodule
